// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared state type, CRC16/USB constants and byte-wise CRC update
package usb_tx_pkg;
  typedef enum logic [1:0] {IDLE, DATA, CRC1, CRC2} usb_tx_state_t;
  localparam logic [15:0] CRC16_POLY_R = 16'hA001;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] din);
    logic [15:0] c;
    c = crc ^ {8'h00, din};
    for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ CRC16_POLY_R : c >> 1;
    return c;
  endfunction
endpackage

// File: rtl/usb_crc16_reg.sv
// usb_crc16_reg: CRC16/USB accumulator (clk, reset, init -> FFFF, en folds din into crc)
module usb_crc16_reg
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [15:0] crc
);
  always_ff @(posedge clk)
    crc <= (reset || init) ? CRC16_INIT : en ? crc16_upd(crc, din) : crc;
endmodule

// File: rtl/usb_tx_crc_framer.sv
// usb_tx_crc_framer: USB TX data-packet framer, payload pass-through + CRC16 trailer, optional beat history tx_hist under USB_TX_HIST_EN
module usb_tx_crc_framer
  import usb_tx_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int HIST_DEPTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  send_data,
  input  logic                  zlp,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  len_err,
  output logic [HIST_DEPTH-1:0] tx_hist
);
  localparam int CW = $clog2(MAX_LEN + 1);
  usb_tx_state_t state;
  logic [CW-1:0] count;
  logic [15:0] crc;
  logic beat, at_max, fin, start;
  assign start = state == IDLE && send_data;
  assign beat = state == DATA && in_valid && tx_ready;
  assign at_max = count == CW'(MAX_LEN - 1);
  assign fin = beat && (in_last || at_max);
  assign len_err = beat && at_max && !in_last;
  assign busy = state != IDLE;
  assign in_ready = state == DATA && tx_ready;
  assign tx_valid = state == DATA ? in_valid : state != IDLE;
  assign tx_data = state == DATA ? in_data : state == CRC1 ? ~crc[7:0] : state == CRC2 ? ~crc[15:8] : 8'h00;
  usb_crc16_reg u_crc (
    .clk(clk),
    .reset(reset),
    .init(start),
    .en(beat),
    .din(in_data),
    .crc(crc)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= start ? (zlp ? CRC1 : DATA) : fin ? CRC1 : (state == CRC1 && tx_ready) ? CRC2 : (state == CRC2 && tx_ready) ? IDLE : state;
      count <= state == IDLE ? '0 : beat ? count + 1'b1 : count;
    end
`ifdef USB_TX_HIST_EN
  always_ff @(posedge clk)
    tx_hist <= reset ? '0 : HIST_DEPTH'({tx_hist, tx_valid & tx_ready});
`else
  assign tx_hist = '0;
`endif
endmodule

// File: tb/tb_usb_tx_crc_framer.sv
// tb_usb_tx_crc_framer: directed bench with a packet-level reference model for two framer instances (MAX_LEN 64 and 4)
module tb_usb_tx_crc_framer;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset = 1;
  logic [1:0] send_data = 0, zlp = 0, in_valid = 0, in_last = 0, tx_ready = 0;
  logic [1:0] in_ready, tx_valid, busy, len_err;
  logic [1:0][7:0] in_data = 0, tx_data;
  logic [1:0][9:0] tx_hist;
  int errors = 0, checks = 0;
  usb_tx_crc_framer #(.MAX_LEN(64), .HIST_DEPTH(10)) u0 (
    .clk(clk), .reset(reset), .send_data(send_data[0]), .zlp(zlp[0]), .in_data(in_data[0]),
    .in_valid(in_valid[0]), .in_last(in_last[0]), .in_ready(in_ready[0]), .tx_data(tx_data[0]),
    .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .busy(busy[0]), .len_err(len_err[0]), .tx_hist(tx_hist[0])
  );
  usb_tx_crc_framer #(.MAX_LEN(4), .HIST_DEPTH(10)) u1 (
    .clk(clk), .reset(reset), .send_data(send_data[1]), .zlp(zlp[1]), .in_data(in_data[1]),
    .in_valid(in_valid[1]), .in_last(in_last[1]), .in_ready(in_ready[1]), .tx_data(tx_data[1]),
    .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .busy(busy[1]), .len_err(len_err[1]), .tx_hist(tx_hist[1])
  );
  int maxl[2] = '{64, 4};
  bit started = 0;
  bit m_busy[2], m_pass[2], acc[2];
  int m_n[2], m_tl[2], logn[2], lerr[2];
  logic [15:0] m_tr[2];
  logic [31:0] m_h[2];
  byte unsigned m_buf[2][0:1023];
  byte unsigned logb[2][0:31];
  byte unsigned src[0:15];
  byte unsigned e_abc[0:10] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
  byte unsigned e_zlp[0:10] = '{8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  logic e_v, e_r, e_e;
  logic [7:0] e_d;
  int got, l0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc_of(int k);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < m_n[k]; i++)
      for (int b = 0; b < 8; b++) begin
        logic fb = c[0] ^ m_buf[k][i][b];
        c = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    return c;
  endfunction

  function automatic void mk_tr(int k);
    m_tr[k] = ~crc_of(k);
    m_tl[k] = 2;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      e_v = m_busy[k] && (m_pass[k] ? in_valid[k] : 1'b1);
      e_d = m_pass[k] ? in_data[k] : (m_tl[k] == 2 ? m_tr[k][7:0] : m_tr[k][15:8]);
      e_r = m_pass[k] && tx_ready[k];
      e_e = m_pass[k] && in_valid[k] && tx_ready[k] && m_n[k] == maxl[k] - 1 && !in_last[k];
      if (started) begin
        chk($sformatf("tx_valid%0d", k), 32'(tx_valid[k]), 32'(e_v));
        if (e_v) chk($sformatf("tx_data%0d", k), 32'(tx_data[k]), 32'(e_d));
        chk($sformatf("in_ready%0d", k), 32'(in_ready[k]), 32'(e_r));
        chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(m_busy[k]));
        chk($sformatf("len_err%0d", k), 32'(len_err[k]), 32'(e_e));
`ifdef USB_TX_HIST_EN
        chk($sformatf("tx_hist%0d", k), 32'(tx_hist[k]), 32'(m_h[k][9:0]));
`else
        chk($sformatf("tx_hist%0d", k), 32'(tx_hist[k]), 0);
`endif
      end
      acc[k] = in_valid[k] && in_ready[k];
      if (tx_valid[k] && tx_ready[k] && logn[k] < 32) begin
        logb[k][logn[k]] = tx_data[k];
        logn[k]++;
      end
      if (len_err[k]) lerr[k]++;
      if (reset) begin
        m_busy[k] = 0;
        m_pass[k] = 0;
        m_tl[k] = 0;
        m_h[k] = 0;
      end else if (started) begin
        m_h[k] = {m_h[k][30:0], e_v & tx_ready[k]};
        if (!m_busy[k]) begin
          if (send_data[k]) begin
            m_busy[k] = 1;
            m_n[k] = 0;
            m_pass[k] = !zlp[k];
            if (zlp[k]) mk_tr(k);
          end
        end else if (m_pass[k]) begin
          if (in_valid[k] && tx_ready[k]) begin
            m_buf[k][m_n[k]] = in_data[k];
            m_n[k]++;
            if (in_last[k] || m_n[k] == maxl[k]) begin
              m_pass[k] = 0;
              mk_tr(k);
            end
          end
        end else if (tx_ready[k]) begin
          m_tl[k]--;
          if (m_tl[k] == 0) m_busy[k] = 0;
        end
      end
    end
    if (reset) started = 1;
  end

  task automatic pkt(int k, int n, bit z, bit last, bit tog, int stall, int abort, output int cnt);
    int cyc = 0, st = 0;
    cnt = 0;
    logn[k] = 0;
    send_data[k] = 1;
    zlp[k] = z;
    @(posedge clk) #1;
    send_data[k] = 0;
    zlp[k] = 0;
    while (m_busy[k] && cyc < 300) begin
      if (abort > 0 && cnt == abort) begin
        reset = 1;
        in_valid[k] = 0;
        tx_ready[k] = 0;
        @(posedge clk) #1;
        reset = 0;
        return;
      end
      in_valid[k] = cnt < n;
      in_data[k] = cnt < 16 ? src[cnt] : 8'h00;
      in_last[k] = last && cnt == n - 1;
      if (m_busy[k] && !m_pass[k] && m_tl[k] == 2 && st < stall) begin
        tx_ready[k] = 0;
        st++;
      end else tx_ready[k] = tog ? (cyc % 2 == 0) : 1'b1;
      @(posedge clk) #1;
      if (acc[k]) cnt++;
      cyc++;
    end
    in_valid[k] = 0;
    in_last[k] = 0;
    tx_ready[k] = 0;
    if (cyc >= 300) chk("timeout", 1, 0);
  endtask

  task automatic seq_chk(string nm, int k, int n, input byte unsigned e[0:10]);
    chk({nm, "_len"}, logn[k], n);
    for (int i = 0; i < n && i < logn[k]; i++) chk($sformatf("%s_b%0d", nm, i), 32'(logb[k][i]), 32'(e[i]));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(posedge clk) #1;
    chk("rst_busy", 32'(busy[0]), 0);
    chk("rst_tx_valid", 32'(tx_valid[0]), 0);
    chk("rst_in_ready", 32'(in_ready[0]), 0);
    chk("rst_len_err", 32'(len_err[0]), 0);
    chk("rst_tx_data", 32'(tx_data[0]), 0);
    chk("rst_tx_hist", 32'(tx_hist[0]), 0);
    for (int i = 0; i < 9; i++) src[i] = 8'(8'h31 + i);
    pkt(0, 9, 0, 1, 0, 0, 0, got);
    chk("t2_accepted", got, 9);
    seq_chk("t2", 0, 11, e_abc);
    pkt(0, 0, 1, 0, 0, 0, 0, got);
    seq_chk("t3_zlp", 0, 2, e_zlp);
    for (int i = 0; i < 6; i++) src[i] = 8'(8'hA1 + i);
    l0 = lerr[1];
    pkt(1, 6, 0, 0, 0, 0, 0, got);
    chk("t4_accepted", got, 4);
    chk("t4_len_err_pulses", lerr[1] - l0, 1);
    chk("t4_beats", logn[1], 6);
    l0 = lerr[1];
    pkt(1, 4, 0, 1, 0, 0, 0, got);
    chk("t4b_last_at_max_no_err", lerr[1] - l0, 0);
    chk("t4b_beats", logn[1], 6);
    for (int i = 0; i < 9; i++) src[i] = 8'(8'h31 + i);
    pkt(0, 9, 0, 1, 1, 5, 0, got);
    seq_chk("t5", 0, 11, e_abc);
    for (int i = 0; i < 5; i++) src[i] = 8'(8'h10 + i);
    pkt(0, 5, 0, 1, 0, 0, 3, got);
    chk("t6_abort_idle", 32'(busy[0]), 0);
    chk("t6_abort_no_crc", logn[0], 3);
    src[0] = 8'h55;
    src[1] = 8'hAA;
    pkt(0, 2, 0, 1, 0, 0, 0, got);
    chk("t6_new_accepted", got, 2);
    chk("t6_new_beats", logn[0], 4);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
